// File: rtl/spart_pkg.sv
// Shared constants and state encodings for the SPART bus slave.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    localparam int OVS = 16;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud generator: one en16 pulse every db clocks, db==0 disables.
module spart_baud_gen #(
    parameter logic [15:0] DB_RESET = 16'd162
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] db,
    input  logic        db_load,
    output logic        en16
);

    logic [15:0] cnt_q, cnt_d;

    assign en16 = (cnt_q == 16'd1);

    // A zero count only arises from db==0 and stays parked there.
    always_comb begin
        cnt_d = cnt_q;
        if (db_load || en16)
            cnt_d = db;
        else if (cnt_q != 16'd0)
            cnt_d = cnt_q - 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= DB_RESET;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spart.sv
// SPART: bus slave with baud generator, 8N1 transmitter and 8N1 receiver.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET    = 16'd162,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
    localparam logic [3:0] OVS_MID  = 4'(OVS / 2 - 1);

    logic        wr, rd, wr_data, rd_data, db_load, en16, rxs;
    logic [15:0] db_q, db_d;
    logic [7:0]  rd_val;

    tx_state_e   tx_state_q, tx_state_d;
    logic [3:0]  tx_ovs_q, tx_ovs_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  rx_ovs_q, rx_ovs_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rxbuf_q, rxbuf_d;
    logic        rda_q, rda_d, rx_armed_q, rx_armed_d;
    logic [SYNC_STAGES-1:0] rx_sync_q;

    assign wr      = iocs & ~iorw;
    assign rd      = iocs & iorw;
    assign wr_data = wr && (ioaddr == ADDR_DATA);
    assign rd_data = rd && (ioaddr == ADDR_DATA);
    assign db_load = wr && ioaddr[1];
    assign rxs     = rx_sync_q[SYNC_STAGES-1];

    assign rda = rda_q;
    assign tbr = (tx_state_q == TX_IDLE);
    assign txd = txd_q;

    always_comb begin
        rd_val = {6'b0, tbr, rda_q};
        if (ioaddr == ADDR_DATA) rd_val = rxbuf_q;
    end

    assign databus = (rd && !ioaddr[1]) ? rd_val : 8'hzz;

    always_comb begin
        db_d = db_q;
        if (wr && ioaddr == ADDR_DBL) db_d[7:0]  = databus;
        if (wr && ioaddr == ADDR_DBH) db_d[15:8] = databus;
    end

    spart_baud_gen #(.DB_RESET(DB_RESET)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .db      (db_d),
        .db_load (db_load),
        .en16    (en16)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_ovs_d   = tx_ovs_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        unique case (tx_state_q)
            TX_IDLE: if (wr_data) begin
                tx_shift_d = databus;
                tx_ovs_d   = '0;
                tx_state_d = TX_START;
            end
            TX_START: if (en16) begin
                // Line still high here means this en16 opens the start bit.
                if (txd_q) begin
                    txd_d    = 1'b0;
                    tx_ovs_d = '0;
                end else begin
                    tx_ovs_d = tx_ovs_q + 4'd1;
                    if (tx_ovs_q == OVS_LAST) begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = '0;
                        tx_state_d = TX_DATA;
                    end
                end
            end
            TX_DATA: if (en16) begin
                tx_ovs_d = tx_ovs_q + 4'd1;
                if (tx_ovs_q == OVS_LAST) begin
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: if (en16) begin
                tx_ovs_d = tx_ovs_q + 4'd1;
                if (tx_ovs_q == OVS_LAST) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_ovs_d   = rx_ovs_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_armed_d = rx_armed_q;
        rxbuf_d    = rxbuf_q;
        rda_d      = rda_q & ~rd_data;
        unique case (rx_state_q)
            // Armed only after seeing the line high, so a held-low break is not a start.
            RX_IDLE: begin
                if (rxs) begin
                    rx_armed_d = 1'b1;
                end else if (rx_armed_q) begin
                    rx_ovs_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: if (en16) begin
                rx_ovs_d = rx_ovs_q + 4'd1;
                if (rx_ovs_q == OVS_MID) begin
                    rx_ovs_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: if (en16) begin
                rx_ovs_d = rx_ovs_q + 4'd1;
                if (rx_ovs_q == OVS_LAST) begin
                    rx_shift_d = {rxs, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: if (en16) begin
                rx_ovs_d = rx_ovs_q + 4'd1;
                if (rx_ovs_q == OVS_LAST) begin
                    if (rxs) begin
                        rxbuf_d = rx_shift_q;
                        rda_d   = 1'b1;
                    end
                    rx_armed_d = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q       <= DB_RESET;
            tx_state_q <= TX_IDLE;
            tx_ovs_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_ovs_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_armed_q <= 1'b0;
            rxbuf_q    <= '0;
            rda_q      <= 1'b0;
            rx_sync_q  <= '1;
        end else begin
            db_q       <= db_d;
            tx_state_q <= tx_state_d;
            tx_ovs_q   <= tx_ovs_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_ovs_q   <= rx_ovs_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_armed_q <= rx_armed_d;
            rxbuf_q    <= rxbuf_d;
            rda_q      <= rda_d;
            rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

endmodule

// File: tb/tb_spart.sv
// Randomized bench for spart against a cycle-level behavioural model of the serial link.
module tb_spart;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0, iorw = 1'b1, rxd = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] tb_d = 8'h00;
    logic       tb_oe = 1'b0;
    wire  [7:0] databus;
    logic       rda, tbr, txd;

    assign databus = tb_oe ? tb_d : 8'hzz;

    spart dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 1'b0, rx_busy = 1'b0;
    int rx_seq = 0;
    logic [7:0] rx_byte = 8'h00;

    // Model: en16 falls on every db-th edge after the last reload (reset or DB write);
    // a latched byte then occupies 160 pulses as ten 16-pulse bit cells.
    int unsigned n_edge, m_load, m_db;
    bit          m_act, m_pulse, m_was;
    int          m_pul, m_seen;
    logic [7:0]  m_byte, m_buf;
    logic        m_txd, m_tbr, m_rda;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edge = 0; m_load = 0; m_db = 162;
            m_act = 0; m_pul = 0; m_byte = 8'h00;
            m_txd = 1; m_tbr = 1; m_rda = 0; m_buf = 8'h00;
            m_seen = rx_seq;
        end else begin
            n_edge++;
            m_pulse = (m_db != 0) && (((n_edge - m_load) % m_db) == 0);
            m_was = m_act;
            if (m_act && m_pulse) begin
                if (m_pul < 160) m_txd = frame_bit(m_byte, m_pul / 16);
                else begin m_act = 0; m_txd = 1; end
                m_pul++;
            end
            if (iocs && !iorw) begin
                case (ioaddr)
                    2'b00: if (!m_was) begin m_act = 1; m_byte = tb_d; m_pul = 0; end
                    2'b10: begin m_db[7:0]  = tb_d; m_load = n_edge; end
                    2'b11: begin m_db[15:8] = tb_d; m_load = n_edge; end
                    default: ;
                endcase
            end
            if (iocs && iorw && ioaddr == 2'b00) m_rda = 0;
            if (rx_seq != m_seen) begin m_seen = rx_seq; m_rda = 1; m_buf = rx_byte; end
            m_tbr = !m_act;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("txd", txd, m_txd);
            chk("tbr", tbr, m_tbr);
            if (!rx_busy) chk("rda", rda, m_rda);
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); iocs = 1; iorw = 0; ioaddr = a; tb_d = d; tb_oe = 1;
        @(negedge clk); iocs = 0; iorw = 1; tb_oe = 0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); iocs = 1; iorw = 1; ioaddr = a;
        #1 d = databus;
        @(negedge clk); iocs = 0;
    endtask

    task automatic wait_tbr(input int budget, output int cyc);
        cyc = 0;
        while (tbr !== 1'b1 && cyc < budget) begin @(negedge clk); cyc++; end
        chk("tbr_ready", tbr, 1'b1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop_ok, input int bitc);
        rx_busy = 1;
        @(negedge clk); rxd = 0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (bitc) @(negedge clk); end
        rxd = stop_ok;
        repeat (bitc) @(negedge clk);
        rxd = 1;
        if (stop_ok) begin rx_byte = b; rx_seq++; end
        repeat (2) @(negedge clk);
        rx_busy = 0;
    endtask

    int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        logic [7:0] d;
        int cyc, k, dbr;
        logic [7:0] brx, btx;
        bit ok;

        repeat (4) @(negedge clk);
        rst_n = 1; chk_on = 1;

        bus_rd(ADDR_STATUS, d);
        chk("reset_status", d, 8'h02);
        chk("reset_txd", txd, 1'b1);

        bus_wr(ADDR_DATA, 8'h5A);
        chk("tbr_after_latch", tbr, 1'b0);
        bus_rd(ADDR_STATUS, d);
        chk("status_busy", d, 8'h00);
        cyc = 0;
        while (txd === 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        chk("first_en16_edge", n_edge, 162);
        repeat (700) @(negedge clk);
        bus_wr(ADDR_DATA, 8'hFF);
        repeat (2500) @(negedge clk);
        bus_wr(ADDR_DBL, 8'h28);
        bus_wr(ADDR_DBH, 8'h00);
        wait_tbr(12000, cyc);
        repeat (100) @(negedge clk);

        bus_wr(ADDR_DATA, 8'hA5);
        cyc = 0;
        while (txd === 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("a5_start_seen", txd, 1'b0);
        cyc = 0; k = 0;
        while (cyc < 8000) begin
            @(negedge clk); cyc++;
            if (cyc % 640 == 320 && k < 10) begin
                chk($sformatf("a5_bit%0d", k), txd, a5_bits[k]);
                k++;
            end
            if (tbr === 1'b1) break;
        end
        chk("a5_frame_cycles", cyc, 6400);

        rx_frame(8'h3C, 1, 640);
        chk("rx3c_rda", rda, 1'b1);
        bus_rd(ADDR_DATA, d);
        chk("rx3c_data", d, 8'h3C);
        chk("rx3c_rda_cleared", rda, 1'b0);

        @(negedge clk); rxd = 0;
        repeat (200) @(negedge clk); rxd = 1;
        repeat (1000) @(negedge clk);
        chk("false_start_rda", rda, 1'b0);

        rx_frame(8'h55, 0, 640);
        chk("framing_err_rda", rda, 1'b0);
        bus_rd(ADDR_DATA, d);
        chk("framing_err_buf", d, 8'h3C);
        rx_frame(8'h81, 1, 640);
        chk("rx81_rda", rda, 1'b1);
        bus_rd(ADDR_DATA, d);
        chk("rx81_data", d, 8'h81);

        bus_wr(ADDR_DBL, 8'h00);
        bus_wr(ADDR_DATA, 8'h96);
        repeat (300) @(negedge clk);
        chk("db0_txd_idle", txd, 1'b1);
        bus_rd(ADDR_STATUS, d);
        chk("db0_status", d, 8'h00);
        bus_wr(ADDR_DBL, 8'h01);
        wait_tbr(400, cyc);
        chk("db1_frame_cycles", cyc, 161);

        dbr = 3 + int'($urandom % 4);
        bus_wr(ADDR_DBL, 8'(dbr));
        for (int it = 0; it < 10; it++) begin
            brx = 8'($urandom); btx = 8'($urandom); ok = ($urandom % 4) != 0;
            fork
                rx_frame(brx, ok, 16 * dbr);
                begin
                    repeat ($urandom % 50) @(negedge clk);
                    bus_wr(ADDR_DATA, btx);
                    wait_tbr(200 * dbr, cyc);
                end
            join
            repeat ($urandom % 20) @(negedge clk);
            if ($urandom % 3 != 0) begin
                bus_rd(ADDR_DATA, d);
                chk("rand_rxbuf", d, m_buf);
            end
            bus_rd(ADDR_STATUS, d);
            chk("rand_status", d, {6'b0, m_tbr, m_rda});
        end

        bus_wr(ADDR_DBL, 8'h28);
        rx_frame(8'h77, 1, 640);
        bus_wr(ADDR_DATA, 8'hC3);
        repeat (1500) @(negedge clk);
        bus_wr(ADDR_DATA, 8'h11);
        repeat (1500) @(negedge clk);
        @(negedge clk);
        #3 rst_n = 0;
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_tbr", tbr, 1'b1);
        chk("rst_rda", rda, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2000) @(negedge clk);
        bus_rd(ADDR_DATA, d);
        chk("rst_rxbuf", d, 8'h00);
        bus_rd(ADDR_STATUS, d);
        chk("rst_status", d, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
